// File: rtl/key_click_decoder.sv
// key_click_decoder: classifies debounced key presses into single/double/triple click pulses.
// Define KEY_CLICK_STATUS_EN to add the last_clicks and gesture_cnt status ports.
module key_click_decoder #(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int TIMER_W       = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pulse,
    input  logic       enable,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click,
    output logic       busy
`ifdef KEY_CLICK_STATUS_EN
    ,
    output logic [1:0] last_clicks,
    output logic [7:0] gesture_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;

    state_t               state, state_d;
    logic [1:0]           clicks, clicks_d;
    logic [TIMER_W-1:0]   timer, timer_d;
    logic                 timeout;
    logic                 emit_d, single_d, double_d, triple_d, busy_d;

    assign timeout = timer == TIMER_W'(WINDOW_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clicks       <= '0;
            timer        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            clicks       <= clicks_d;
            timer        <= timer_d;
            single_click <= single_d;
            double_click <= double_d;
            triple_click <= triple_d;
            busy         <= busy_d;
        end
    end

    // Abort beats a pulse, and a pulse beats the window timeout.
    always_comb begin
        state_d  = state;
        clicks_d = clicks;
        timer_d  = '0;
        case (state)
            IDLE: begin
                if (key_pulse && enable) begin
                    state_d  = COUNT;
                    clicks_d = 2'd1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d  = IDLE;
                    clicks_d = '0;
                end else if (key_pulse) begin
                    clicks_d = clicks + 2'd1;
                    state_d  = clicks == 2'd2 ? EMIT : COUNT;
                end else if (timeout) begin
                    state_d = EMIT;
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                clicks_d = '0;
            end
        endcase
    end

    always_comb begin
        emit_d   = state_d == EMIT;
        single_d = emit_d && clicks_d == 2'd1;
        double_d = emit_d && clicks_d == 2'd2;
        triple_d = emit_d && clicks_d == 2'd3;
        busy_d   = state_d != IDLE;
    end

`ifdef KEY_CLICK_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_clicks <= '0;
            gesture_cnt <= '0;
        end else if (emit_d) begin
            last_clicks <= clicks_d;
            gesture_cnt <= gesture_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: randomized scoreboard bench for key_click_decoder.
// Reference model reasons in click timestamps; a negedge monitor checks every cycle.
module tb_key_click_decoder;
    localparam int W = 100;

    logic clk = 1'b0, rst_n = 1'b0, key_pulse = 1'b0, enable = 1'b0;
    logic single_click, double_click, triple_click, busy;
`ifdef KEY_CLICK_STATUS_EN
    logic [1:0] last_clicks;
    logic [7:0] gesture_cnt;
`endif

    key_click_decoder #(.WINDOW_CYCLES(W), .TIMER_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .enable(enable),
        .single_click(single_click), .double_click(double_click),
        .triple_click(triple_click), .busy(busy)
`ifdef KEY_CLICK_STATUS_EN
        , .last_clicks(last_clicks), .gesture_cnt(gesture_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int k; int g;} ev_t;
    typedef struct {int c; int b;} bz_t;
    ev_t evq[$];
    bz_t bq[$];

    int checks = 0, failures = 0;
    int n = 0, last = 0, emit_at = -1, gcnt = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    task automatic emit(input int c, input int k);
        gcnt = (gcnt + 1) % 256;
        evq.push_back('{c + 1, k, gcnt});
        emit_at = c + 1;
        n = 0;
    endtask

    // A gesture ends on the third click or when W cycles pass since the last click.
    task automatic model(input int c, input bit k, input bit e, input bit r);
        if (!r) begin
            n = 0;
            emit_at = -1;
            gcnt = 0;
            while (evq.size() > 0 && evq[$].c >= c) void'(evq.pop_back());
            bq.push_back('{c + 1, 0});
            return;
        end
        if (emit_at == c) begin
        end else if (n == 0) begin
            if (k && e) begin
                n = 1;
                last = c;
            end
        end else if (!e) begin
            n = 0;
        end else if (k) begin
            n++;
            last = c;
            if (n == 3) emit(c, 3);
        end else if (c - last == W) begin
            emit(c, n);
        end
        bq.push_back('{c + 1, int'(n != 0 || emit_at == c + 1)});
    endtask

    task automatic step(input bit k, input bit e, input bit r);
        @(posedge clk);
        #1;
        key_pulse = k;
        enable = e;
        rst_n = r;
        model(cyc, k, e, r);
    endtask

    task automatic idle(input int cnt);
        repeat (cnt) step(1'b0, 1'b1, 1'b1);
    endtask

    always @(negedge clk) begin
        int exp_k, want;
        while (bq.size() > 0 && bq[0].c < cyc) void'(bq.pop_front());
        if (!rst_n) begin
            chk("reset_outputs", {single_click, double_click, triple_click, busy}, 0);
`ifdef KEY_CLICK_STATUS_EN
            chk("reset_status", {last_clicks, gesture_cnt}, 0);
`endif
        end else begin
            if (bq.size() > 0 && bq[0].c == cyc) begin
                chk("busy", busy, bq[0].b);
                void'(bq.pop_front());
            end
            exp_k = (evq.size() > 0 && evq[0].c == cyc) ? evq[0].k : 0;
            want = exp_k == 0 ? 0 : 1 << (exp_k - 1);
            chk("click_pulses", {triple_click, double_click, single_click}, want);
            if (exp_k != 0) begin
`ifdef KEY_CLICK_STATUS_EN
                chk("last_clicks", last_clicks, exp_k);
                chk("gesture_cnt", gesture_cnt, evq[0].g);
`endif
                void'(evq.pop_front());
            end
        end
    end

    initial begin
        int g;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 1'b1); idle(150);
        step(1'b1, 1'b1, 1'b1); idle(49); step(1'b1, 1'b1, 1'b1); idle(150);
        step(1'b1, 1'b1, 1'b1); idle(98); step(1'b1, 1'b1, 1'b1); idle(98);
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1); idle(150);
        step(1'b1, 1'b1, 1'b1); idle(39); step(1'b0, 1'b0, 1'b1); idle(260);
        step(1'b1, 1'b1, 1'b1); idle(59); repeat (3) step(1'b0, 1'b1, 1'b0);
        idle(200); step(1'b1, 1'b1, 1'b1); idle(150);
        repeat (260) begin
            repeat (3) step(1'b1, 1'b1, 1'b1);
            idle(2);
        end
        repeat (300) begin
            case ($urandom_range(0, 5))
                0: g = W - 1;
                1: g = W;
                2: g = W + 1;
                3: g = int'($urandom_range(0, 10));
                4: g = W - 2;
                default: g = int'($urandom_range(0, 130));
            endcase
            repeat (g) step(1'b0, $urandom_range(0, 31) != 0, 1'b1);
            if ($urandom_range(0, 49) == 0) step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1);
        end
        idle(150);
        chk("drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
